rv_prefetch: RTL and testbench

RV_PREFETCH -- requirements
Module: rv_prefetch

---
 rtl/rv_prefetch.sv | 129 ++++++++++++
 tb/tb_rv_prefetch.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rv_prefetch.sv
// Instruction prefetcher: one outstanding fetch into a DEPTH-entry circular queue.
// Optional macro RV_PREFETCH_BACK2BACK_EN issues the next fetch in the response cycle.
module rv_prefetch #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             reset_vector,
  output logic [31:0]             mem_i_addr,
  output logic                    mem_i_rstrb,
  input  logic [31:0]             mem_i_rdata,
  input  logic                    mem_i_rbusy,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  output logic                    insn_valid,
  output logic [31:0]             insn,
  output logic [31:0]             insn_pc,
  input  logic                    insn_ready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [AW-1:0]   head_reg, head_next;
  logic [AW-1:0]   tail_reg, tail_next;
  logic            discard_reg, discard_next;
  logic            push, pop;

  // Each entry holds {pc, instruction word}
  logic [63:0]     q_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= reset_vector;
      count_reg    <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
      discard_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      count_reg    <= count_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      discard_reg  <= discard_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_mem[tail_reg] <= {fetch_pc_reg, mem_i_rdata};
    end
  end

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    discard_next  = discard_reg;
    mem_i_rstrb   = 1'b0;
    mem_i_addr    = fetch_pc_reg;
    push          = 1'b0;

    case (state_reg)
      IDLE: begin
        // Issue depends only on registered occupancy, never on a same-cycle pop
        if (!redirect && !mem_i_rbusy && (count_reg < DEPTH_C)) begin
          mem_i_rstrb = 1'b1;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        if (!mem_i_rbusy) begin
          state_next   = IDLE;
          discard_next = 1'b0;
          if (!redirect && !discard_reg) begin
            push          = 1'b1;
            fetch_pc_next = fetch_pc_reg + 32'd4;
`ifdef RV_PREFETCH_BACK2BACK_EN
            if ((count_reg + CW'(1)) < DEPTH_C) begin
              mem_i_rstrb = 1'b1;
              mem_i_addr  = fetch_pc_reg + 32'd4;
              state_next  = WAIT;
            end
`endif
          end
        end else if (redirect) begin
          discard_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (redirect) begin
      fetch_pc_next = redirect_pc;
    end
    if (rst) begin
      mem_i_rstrb = 1'b0;
    end
  end

  assign insn_valid = (count_reg != '0);
  assign pop        = insn_valid && insn_ready && !redirect;

  // Redirect flushes the queue and overrides any push or pop
  always_comb begin
    if (redirect) begin
      count_next = '0;
      head_next  = tail_reg;
      tail_next  = tail_reg;
    end else begin
      count_next = count_reg + CW'(push) - CW'(pop);
      head_next  = head_reg + AW'(pop);
      tail_next  = tail_reg + AW'(push);
    end
  end

  assign insn    = q_mem[head_reg][31:0];
  assign insn_pc = q_mem[head_reg][63:32];
  assign count   = count_reg;

endmodule

// File: tb/tb_rv_prefetch.sv
// Directed bench for rv_prefetch; expectations adapt when RV_PREFETCH_BACK2BACK_EN is defined.
module tb_rv_prefetch;

`ifdef RV_PREFETCH_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  localparam logic [31:0] KEY = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] reset_vector;
  logic [31:0] mem_i_addr;
  logic        mem_i_rstrb;
  logic [31:0] mem_i_rdata;
  logic        mem_i_rbusy;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        insn_valid;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_ready;
  logic [2:0]  count;

  int passed = 0;
  int total  = 0;

  rv_prefetch #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .reset_vector(reset_vector),
    .mem_i_addr(mem_i_addr), .mem_i_rstrb(mem_i_rstrb),
    .mem_i_rdata(mem_i_rdata), .mem_i_rbusy(mem_i_rbusy),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .insn_valid(insn_valid), .insn(insn), .insn_pc(insn_pc),
    .insn_ready(insn_ready), .count(count)
  );

  always #5 clk = ~clk;

  // Memory returns a word derived from the last requested address
  logic [31:0] req_addr = 32'h0;
  always @(posedge clk) if (mem_i_rstrb) req_addr <= mem_i_addr;
  assign mem_i_rdata = req_addr ^ KEY;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller settled inside cycle 0 (first cycle with rst=0)
  task automatic do_reset(input logic [31:0] rv);
    rst = 1'b1; reset_vector = rv; redirect = 1'b0;
    cyc(); cyc();
    #1;
    chk("rst_valid", 32'(insn_valid), 32'd0);
    chk("rst_rstrb", 32'(mem_i_rstrb), 32'd0);
    chk("rst_addr", mem_i_addr, rv);
    chk("rst_count", 32'(count), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int pops;
    rst = 1'b1; reset_vector = 32'h0; mem_i_rbusy = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; insn_ready = 1'b1;

    // Zero-wait fetch sequence from 0x1000
    do_reset(32'h0000_1000);
    chk("c0_rstrb", 32'(mem_i_rstrb), 32'd1);
    chk("c0_addr", mem_i_addr, 32'h1000);
    chk("c0_valid", 32'(insn_valid), 32'd0);
    cyc(); #1;
    chk("c1_rstrb", 32'(mem_i_rstrb), B2B ? 32'd1 : 32'd0);
    chk("c1_valid", 32'(insn_valid), 32'd0);
    cyc(); #1;
    chk("c2_valid", 32'(insn_valid), 32'd1);
    chk("c2_pc", insn_pc, 32'h1000);
    chk("c2_insn", insn, 32'h1000 ^ KEY);
    chk("c2_addr", mem_i_addr, B2B ? 32'h1008 : 32'h1004);
    cyc(); #1;
    chk("c3_valid", 32'(insn_valid), B2B ? 32'd1 : 32'd0);
    cyc(); #1;
    chk("c4_pc", insn_pc, B2B ? 32'h1008 : 32'h1004);
    chk("c4_addr", mem_i_addr, B2B ? 32'h1010 : 32'h1008);
    chk("c4_rstrb", 32'(mem_i_rstrb), 32'd1);

    // Backpressure fills the queue, then a single pop re-enables issue
    insn_ready = 1'b0;
    do_reset(32'h0000_4000);
    for (int i = 0; i < 30 && count != 3'd4; i++) cyc();
    chk("bp_full", 32'(count), 32'd4);
    for (int i = 0; i < 3; i++) begin
      chk("bp_stall", 32'(mem_i_rstrb), 32'd0);
      cyc();
    end
    insn_ready = 1'b1; #1;
    chk("bp_head", insn_pc, 32'h4000);
    chk("bp_nopath", 32'(mem_i_rstrb), 32'd0);
    cyc(); insn_ready = 1'b0; #1;
    chk("bp_count3", 32'(count), 32'd3);
    chk("bp_reissue", 32'(mem_i_rstrb), 32'd1);
    chk("bp_addr", mem_i_addr, 32'h4010);
    chk("bp_head2", insn_pc, 32'h4004);

    // Redirect while the fetch is stalled: stale word must be dropped
    insn_ready = 1'b1;
    do_reset(32'h0000_3000);
    chk("rd_issue", 32'(mem_i_rstrb), 32'd1);
    cyc(); mem_i_rbusy = 1'b1; redirect = 1'b1; redirect_pc = 32'h2000; #1;
    chk("rd_nostrb", 32'(mem_i_rstrb), 32'd0);
    cyc(); redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rd_empty", 32'(count), 32'd0);
      cyc();
    end
    mem_i_rbusy = 1'b0; #1;
    chk("rd_drop_strb", 32'(mem_i_rstrb), 32'd0);
    cyc(); #1;
    chk("rd_drop_cnt", 32'(count), 32'd0);
    chk("rd_new_strb", 32'(mem_i_rstrb), 32'd1);
    chk("rd_new_addr", mem_i_addr, 32'h2000);
    cyc(); cyc(); #1;
    chk("rd_pc", insn_pc, 32'h2000);
    chk("rd_insn", insn, 32'h2000 ^ KEY);

    // Redirect coinciding with the response
    insn_ready = 1'b0;
    do_reset(32'h0000_5000);
    cyc(); redirect = 1'b1; redirect_pc = 32'h6000; #1;
    chk("rs_nostrb", 32'(mem_i_rstrb), 32'd0);
    cyc(); redirect = 1'b0; #1;
    chk("rs_cnt", 32'(count), 32'd0);
    chk("rs_addr", mem_i_addr, 32'h6000);
    cyc(); cyc(); #1;
    chk("rs_cnt1", 32'(count), 32'd1);
    chk("rs_pc", insn_pc, 32'h6000);

    // Fetch address wraps past the top of the address space
    insn_ready = 1'b1;
    do_reset(32'hFFFF_FFFC);
    chk("wr_addr", mem_i_addr, 32'hFFFF_FFFC);
    for (int i = 0; i < 10 && !insn_valid; i++) cyc();
    chk("wr_pc0", insn_pc, 32'hFFFF_FFFC);
    cyc();
    for (int i = 0; i < 10 && !insn_valid; i++) cyc();
    chk("wr_pc1", insn_pc, 32'h0000_0000);
    chk("wr_insn1", insn, KEY);

    // Throughput over cycles 0..9 with zero-wait memory
    do_reset(32'h0000_8000);
    pops = 0;
    for (int k = 0; k < 10; k++) begin
      if (insn_valid) begin
        chk("tp_pc", insn_pc, 32'h8000 + 32'(4 * pops));
        pops++;
      end
`ifdef RV_PREFETCH_BACK2BACK_EN
      if (k <= 8) chk("tp_strb", 32'(mem_i_rstrb), 32'd1);
`endif
      chk("tp_bound", 32'(count <= 3'd4), 32'd1);
      cyc();
    end
    chk("tp_pops", 32'(pops), B2B ? 32'd8 : 32'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
